alarm_ctrl: RTL
===============

ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, clk cycles per one-second tick.
REQ-002 SHALL have parameter RING_SECONDS, default 30, maximum ringing duration in ticks.
REQ-003 SHALL have port clk, input, 1, single clock domain, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; one clock, asynchronous, active-low.
REQ-005 SHALL have ports btn_mode, btn_hour, btn_min, input, 1 each, debounced single-cycle press pulses.
REQ-006 SHALL have port alarm_en, input, 1, level switch arming the alarm.
REQ-007 SHALL have ports h_tens, h_units, m_tens, m_units, s_tens, s_units, input, 4 each, current time BCD from time counter.
REQ-008 SHALL have port tick, output, 1, one-cycle second pulse driving time counter add_second.
REQ-009 SHALL have ports time_add_hour, time_add_minute, output, 1 each, one-cycle config pulses to time counter.
REQ-010 SHALL have port time_cfg_en, output, 1, high only in SET_TIME.
REQ-011 SHALL have ports a_h_tens, a_h_units, a_m_tens, a_m_units, output, 4 each, stored alarm time BCD.
REQ-012 SHALL have ports show_alarm, output, 1, high only in SET_ALARM; ringing, output, 1, high only in RING.

Function
REQ-013 SHALL implement FSM states NORMAL, SET_TIME, SET_ALARM, RING; all outputs registered.
REQ-014 SHALL move NORMAL->SET_TIME->SET_ALARM->NORMAL on each btn_mode pulse, one cycle latency.
REQ-015 SHALL run prescaler 0..TICK_DIV-1 and assert tick for exactly the cycle after count reaches TICK_DIV-1, wrapping to 0.
REQ-016 SHALL hold prescaler at 0 and suppress tick while in SET_TIME; counting resumes from 0 on exit.
REQ-017 SHALL, in SET_TIME, forward btn_hour/btn_min as time_add_hour/time_add_minute one cycle later, one pulse per press.
REQ-018 SHALL force time_add_hour and time_add_minute low outside SET_TIME.
REQ-019 SHALL, in SET_ALARM, increment alarm hour BCD on btn_hour, 09->10, 19->20, 23->00.
REQ-020 SHALL, in SET_ALARM, increment alarm minute BCD on btn_min, x9->(x+1)0, 59->00, no carry into hour.
REQ-021 SHALL give btn_mode priority: a btn_hour/btn_min in the same cycle as btn_mode is ignored.
REQ-022 SHALL compute match = alarm_en AND HH:MM equals alarm AND s_tens=0 AND s_units=0, registered as match_q.
REQ-023 SHALL enter RING from NORMAL only on rising edge of match (match=1, match_q=0); no trigger in SET_TIME/SET_ALARM.
REQ-024 SHALL count ticks in RING and return to NORMAL after RING_SECONDS ticks, or on next cycle after any button pulse.
REQ-025 SHALL consume the button that stops RING: no mode change, no config pulse, no alarm edit.
REQ-026 SHALL return RING->NORMAL on the cycle after alarm_en drops.
REQ-027 SHALL keep tick running in NORMAL, SET_ALARM and RING.

Reset
REQ-028 SHALL on rst low immediately force state NORMAL, prescaler 0, ring counter 0, match_q 0.
REQ-029 SHALL reset outputs: tick 0, time_add_hour 0, time_add_minute 0, time_cfg_en 0, show_alarm 0, ringing 0, alarm 00:00.
REQ-030 SHALL produce first tick TICK_DIV cycles after rst deasserts; reset mid-RING or mid-SET_* aborts cleanly to NORMAL.

Verification
REQ-031 TICK_DIV=4, release reset -> tick high on cycles 4, 8, 12 after release, single-cycle each.
REQ-032 btn_mode x1, btn_hour x2 -> time_cfg_en=1, two time_add_hour pulses, no tick while in SET_TIME.
REQ-033 In SET_ALARM, 23 btn_hour + 59 btn_min -> alarm 23:59; one more each -> 00:00.
REQ-034 Alarm 07:30, alarm_en=1, drive time 07:29:59 then 07:30:00 -> ringing=1 next cycle; holding 07:30:00 does not retrigger after stop.
REQ-035 RING_SECONDS=3 -> ringing clears after 3rd tick; repeat and press btn_hour -> ringing clears, no alarm edit, state NORMAL.
REQ-036 Assert rst low during RING and SET_ALARM -> all outputs at reset values same cycle, alarm 00:00.

Source files
------------

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: mode FSM, one-second prescaler, alarm time storage
// and ring control in front of an external BCD time counter.
module alarm_ctrl #(
    parameter int unsigned TICK_DIV     = 100000000,
    parameter int unsigned RING_SECONDS = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_hour,
    input  logic       btn_min,
    input  logic       alarm_en,
    input  logic [3:0] h_tens,
    input  logic [3:0] h_units,
    input  logic [3:0] m_tens,
    input  logic [3:0] m_units,
    input  logic [3:0] s_tens,
    input  logic [3:0] s_units,
    output logic       tick,
    output logic       time_add_hour,
    output logic       time_add_minute,
    output logic       time_cfg_en,
    output logic [3:0] a_h_tens,
    output logic [3:0] a_h_units,
    output logic [3:0] a_m_tens,
    output logic [3:0] a_m_units,
    output logic       show_alarm,
    output logic       ringing
);

    localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned RING_W = (RING_SECONDS > 1) ? $clog2(RING_SECONDS + 1) : 1;

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2,
        RING      = 2'd3
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [RING_W-1:0] ring_cnt;
    logic              match;
    logic              match_q;
    logic              any_btn;
    logic              ring_done;
    logic [3:0]        hr_tens_n;
    logic [3:0]        hr_units_n;
    logic [3:0]        mn_tens_n;
    logic [3:0]        mn_units_n;

    // Alarm condition at the top of the matching minute
    always_comb begin
        match = alarm_en
              && (h_tens == a_h_tens) && (h_units == a_h_units)
              && (m_tens == a_m_tens) && (m_units == a_m_units)
              && (s_tens == 4'd0) && (s_units == 4'd0);
        any_btn   = btn_mode || btn_hour || btn_min;
        ring_done = (state == RING) && tick
                  && (ring_cnt == RING_W'(RING_SECONDS - 1));
    end

    // Next-state: a new alarm edge wins over a mode press in NORMAL
    always_comb begin
        state_n = state;
        case (state)
            NORMAL: begin
                if (match && !match_q) state_n = RING;
                else if (btn_mode)     state_n = SET_TIME;
            end
            SET_TIME:  if (btn_mode) state_n = SET_ALARM;
            SET_ALARM: if (btn_mode) state_n = NORMAL;
            RING:      if (!alarm_en || any_btn || ring_done) state_n = NORMAL;
            default:   state_n = NORMAL;
        endcase
    end

    // Next alarm hour (00..23) and minute (00..59) in BCD
    always_comb begin
        hr_tens_n  = a_h_tens;
        hr_units_n = a_h_units + 4'd1;
        if (a_h_tens == 4'd2 && a_h_units == 4'd3) begin
            hr_tens_n  = 4'd0;
            hr_units_n = 4'd0;
        end else if (a_h_units == 4'd9) begin
            hr_tens_n  = a_h_tens + 4'd1;
            hr_units_n = 4'd0;
        end
        mn_tens_n  = a_m_tens;
        mn_units_n = a_m_units + 4'd1;
        if (a_m_units == 4'd9) begin
            mn_units_n = 4'd0;
            mn_tens_n  = (a_m_tens == 4'd5) ? 4'd0 : a_m_tens + 4'd1;
        end
    end

    // FSM state and mode-indicator outputs, aligned with the state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= NORMAL;
            time_cfg_en     <= 1'b0;
            show_alarm      <= 1'b0;
            ringing         <= 1'b0;
            time_add_hour   <= 1'b0;
            time_add_minute <= 1'b0;
            match_q         <= 1'b0;
        end else begin
            state           <= state_n;
            time_cfg_en     <= (state_n == SET_TIME);
            show_alarm      <= (state_n == SET_ALARM);
            ringing         <= (state_n == RING);
            time_add_hour   <= (state == SET_TIME) && btn_hour && !btn_mode;
            time_add_minute <= (state == SET_TIME) && btn_min && !btn_mode;
            match_q         <= match;
        end
    end

    // One-second prescaler, frozen at zero while the time is being set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (state == SET_TIME) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CNT_W'(TICK_DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
        end
    end

    // Seconds spent ringing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ring_cnt <= '0;
        end else if (state != RING) begin
            ring_cnt <= '0;
        end else if (tick) begin
            ring_cnt <= ring_cnt + RING_W'(1);
        end
    end

    // Alarm time edits; a simultaneous mode press cancels the edit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_h_tens  <= 4'd0;
            a_h_units <= 4'd0;
            a_m_tens  <= 4'd0;
            a_m_units <= 4'd0;
        end else if (state == SET_ALARM && !btn_mode) begin
            if (btn_hour) begin
                a_h_tens  <= hr_tens_n;
                a_h_units <= hr_units_n;
            end
            if (btn_min) begin
                a_m_tens  <= mn_tens_n;
                a_m_units <= mn_units_n;
            end
        end
    end

endmodule
